sqr_iter_seq: RTL and testbench
===============================

// Module: sqr_iter_seq
// PURPOSE
//  Iterative shift-and-add squarer: the inverse datapath of the square-root unit (x -> x*x).
//  One operand per start/ready transaction, one bit per two clock cycles.
//  Sits beside the SQRT datapath; also used to check roots (sqrt(x)^2 <= x).
// PARAMETERS
//  DW  8  operand width in bits; result is 2*DW bits; DW >= 2
//  CW  $clog2(DW)+1  internal bit-counter width (derived; do not override)
// PORTS
//  clk      in   1     system clock, all state changes on rising edge
//  rst      in   1     synchronous reset, active-low
//  start    in   1     request; sampled only in IDLE
//  operand  in   DW    value to square; captured on the accepted start edge
//  busy     out  1     high from the edge after an accepted start through the DONE cycle
//  ready    out  1     one-cycle pulse: result valid and updated
//  result   out  2*DW  last completed square; held until the next completion
// BEHAVIOUR
//  - Reset (rst==0 at a rising edge): state=IDLE; busy=0, ready=0, result=0; A/B/acc/count=0.
//    Reset mid-operation aborts it; no ready pulse; result returns to 0.
//  - Registers: A (2*DW, multiplicand), B (DW, multiplier), acc (2*DW), count (CW).
//  - FSM (one state per cycle):
//    IDLE:  start=1 -> A={DW'0,operand}, B=operand, acc=0, count=0, ready=0; go ADD.
//           start=0 -> stay; ready cleared (pulse lasts exactly one cycle).
//    ADD:   if B[0] acc<=acc+A (2*DW-bit add, cannot overflow); go SHIFT.
//    SHIFT: A<=A<<1, B<=B>>1, count<=count+1; count==DW-1 -> DONE, else ADD.
//    DONE:  result<=acc, ready<=1; go IDLE.
//  - busy = (state != IDLE), registered.
//  - Latency: start sampled at edge 0; ready high after edge 2*DW+2 (DW=8: 18 cycles).
//  - Throughput: new start accepted in the same cycle ready is high (back-to-back,
//    one transaction per 2*DW+2 cycles); that start clears ready on the next edge.
//  - start while busy: ignored; operand changes while busy: no effect.
//  - Default state encoding: unreachable codes -> IDLE on the next edge.
// CONFIGURATION
//  SQR_EARLY_EXIT_EN defined:
//    - SHIFT goes to DONE as soon as the shifted B is zero (B>>1==0) or count==DW-1.
//    - IDLE with start=1 and operand==0 goes directly to DONE (result 0, ready after edge 2).
//    - Latency = 2*(msb_index(operand)+1)+2 cycles; operand 0 -> 2 cycles.
//  SQR_EARLY_EXIT_EN undefined: fixed latency 2*DW+2 for every operand, including 0.
//  Result values are identical in both builds.
// TESTING
//  1 DW=8, operand=0xFF, start 1 cycle -> ready 18 cycles later, result=0xFE01, busy
//    high for 17 cycles.
//  2 operand=0x00 -> result=0x0000; ready after 18 cycles (2 with SQR_EARLY_EXIT_EN).
//  3 operand=0x03 with SQR_EARLY_EXIT_EN -> result=0x0009, ready 6 cycles after start.
//  4 operand=0x0C, start, then start=1 with operand=0x55 at cycle 5 -> second start
//    ignored, result=0x0090.
//  5 operand=0xA0, rst=0 at cycle 7 -> next edge busy=0, result=0, no ready pulse;
//    then operand=0x10 -> 0x0100.
//  6 back-to-back: 0x07 then 0x0B issued in the ready cycle -> results 0x0031 then
//    0x0079, ready pulses 18 cycles apart.
//  All tests: compare against a reference model over 1000 random operands, both builds.

Source files
------------

// File: rtl/sqr_iter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sqr_iter_seq
//  Description : Iterative shift-and-add squarer (x -> x*x), one operand per
//                start/ready transaction, one multiplier bit per two cycles.
//                Optional build macro SQR_EARLY_EXIT_EN ends the iteration as
//                soon as the remaining multiplier bits are all zero, and sends
//                a zero operand straight to DONE. Results are identical in
//                both builds; only the latency changes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sqr_iter_seq #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,       // synchronous, active-low
    input  logic            start,
    input  logic [DW-1:0]   operand,
    output logic            busy,
    output logic            ready,
    output logic [2*DW-1:0] result
);

    // Bit-counter width is derived from the operand width.
    localparam int CW = $clog2(DW) + 1;

    localparam logic [CW-1:0] c_LAST_BIT = CW'(DW - 1);

    // FSM encoding: one state per clock cycle.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ADD   = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [2*DW-1:0] r_a;        // multiplicand, shifted left each bit
    logic [DW-1:0]   r_b;        // multiplier, shifted right each bit
    logic [2*DW-1:0] r_acc;      // partial-product accumulator
    logic [CW-1:0]   r_count;    // multiplier bits consumed so far
    logic            r_busy;
    logic            r_ready;
    logic [2*DW-1:0] r_result;
    logic [DW-1:0]   w_b_shift;
    logic            w_last;

    assign w_b_shift = r_b >> 1;

    // Iteration ends after the last multiplier bit, or (early-exit build)
    // once no set bits remain in the multiplier.
`ifdef SQR_EARLY_EXIT_EN
    assign w_last = (r_count == c_LAST_BIT) || (w_b_shift == '0);
`else
    assign w_last = (r_count == c_LAST_BIT);
`endif

    // Next-state decode; unused codes fall back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
`ifdef SQR_EARLY_EXIT_EN
                    if (operand == '0) begin
                        w_next_state = c_ST_DONE;
                    end else begin
                        w_next_state = c_ST_ADD;
                    end
`else
                    w_next_state = c_ST_ADD;
`endif
                end
            end
            c_ST_ADD:   w_next_state = c_ST_SHIFT;
            c_ST_SHIFT: w_next_state = w_last ? c_ST_DONE : c_ST_ADD;
            c_ST_DONE:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= c_ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            // Registered copy of (state != IDLE), aligned with r_state.
            r_busy  <= (w_next_state != c_ST_IDLE);
            case (r_state)
                c_ST_IDLE: begin
                    // The ready pulse always ends after one cycle in IDLE,
                    // whether or not a new operand is accepted.
                    r_ready <= 1'b0;
                    if (start) begin
                        r_a     <= {{DW{1'b0}}, operand};
                        r_b     <= operand;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                c_ST_ADD: begin
                    // Sum is bounded by operand^2 < 2^(2*DW): no overflow.
                    if (r_b[0]) begin
                        r_acc <= r_acc + r_a;
                    end
                end
                c_ST_SHIFT: begin
                    r_a     <= r_a << 1;
                    r_b     <= w_b_shift;
                    r_count <= r_count + CW'(1);
                end
                c_ST_DONE: begin
                    r_result <= r_acc;
                    r_ready  <= 1'b1;
                end
                default: begin
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign ready  = r_ready;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sqr_iter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sqr_iter_seq
//  Description : Self-checking bench for sqr_iter_seq. Directed cases plus
//                1000 random operands compared against an arithmetic model
//                (square, latency, busy length). Honours SQR_EARLY_EXIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sqr_iter_seq;

    localparam int DW = 8;

`ifdef SQR_EARLY_EXIT_EN
    localparam bit c_EARLY = 1'b1;
`else
    localparam bit c_EARLY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [DW-1:0]   operand;
    logic            busy;
    logic            ready;
    logic [2*DW-1:0] result;

    int n_vec = 0;
    int n_err = 0;

    sqr_iter_seq #(.DW(DW)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .operand (operand),
        .busy    (busy),
        .ready   (ready),
        .result  (result)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycles from the start cycle to the ready cycle, from the operand value.
    function automatic int exp_lat(input logic [DW-1:0] op);
        int msb;
        int full;
        int early;
        msb = -1;
        for (int i = 0; i < DW; i++) begin
            if (op[i]) msb = i;
        end
        full  = 2 * DW + 2;
        early = (msb < 0) ? 2 : 2 * (msb + 1) + 2;
        return c_EARLY ? early : full;
    endfunction

    // One transaction; returns in the cycle where ready is high.
    // While busy, start/operand are toggled randomly to show they are ignored.
    task automatic run_op(input logic [DW-1:0] op, input string tag,
                          output logic [2*DW-1:0] res_exp);
        int v;
        int lat;
        int n;
        int nb;
        v       = int'(op);
        res_exp = (2*DW)'(v * v);
        lat     = exp_lat(op);
        start   = 1'b1;
        operand = op;
        tick;
        start   = 1'b0;
        chk_val({tag, " busy_after_start"}, 32'(busy), 32'd1);
        chk_val({tag, " ready_cleared"}, 32'(ready), 32'd0);
        n  = 1;
        nb = busy ? 1 : 0;
        while (!ready && n < 4 * DW + 8) begin
            if (n <= lat - 2) begin
                start = $urandom_range(1);
            end else begin
                start = 1'b0;
            end
            operand = DW'($urandom);
            tick;
            n++;
            if (busy) nb++;
        end
        start = 1'b0;
        chk_val({tag, " latency"}, 32'(n), 32'(lat));
        chk_val({tag, " result"}, 32'(result), 32'(res_exp));
        chk_val({tag, " busy_at_ready"}, 32'(busy), 32'd0);
        chk_val({tag, " busy_cycles"}, 32'(nb), 32'(lat - 1));
    endtask

    // Idle cycle after a completion: pulse ends, result is held.
    task automatic idle_check(input string tag, input logic [2*DW-1:0] res_exp);
        tick;
        chk_val({tag, " ready_pulse_end"}, 32'(ready), 32'd0);
        chk_val({tag, " result_hold"}, 32'(result), 32'(res_exp));
    endtask

    initial begin
        logic [2*DW-1:0] e;
        logic [DW-1:0]   op;
        int              seen;

        rst     = 1'b0;
        start   = 1'b0;
        operand = '0;
        repeat (3) tick;
        chk_val("reset busy", 32'(busy), 32'd0);
        chk_val("reset ready", 32'(ready), 32'd0);
        chk_val("reset result", 32'(result), 32'd0);
        rst = 1'b1;
        tick;

        run_op(8'hFF, "t1_ff", e);
        chk_val("t1 value", 32'(result), 32'h0000FE01);
        idle_check("t1", e);

        run_op(8'h00, "t2_zero", e);
        idle_check("t2", e);

        run_op(8'h03, "t3_three", e);
        chk_val("t3 value", 32'(result), 32'h00000009);
        idle_check("t3", e);

        run_op(8'h0C, "t4_ignore", e);
        chk_val("t4 value", 32'(result), 32'h00000090);
        idle_check("t4", e);

        // Reset in the middle of an operation.
        start   = 1'b1;
        operand = 8'hA0;
        tick;
        start = 1'b0;
        repeat (6) tick;
        rst = 1'b0;
        tick;
        chk_val("t5 abort busy", 32'(busy), 32'd0);
        chk_val("t5 abort result", 32'(result), 32'd0);
        chk_val("t5 abort ready", 32'(ready), 32'd0);
        rst  = 1'b1;
        seen = 0;
        repeat (2 * DW + 4) begin
            tick;
            if (ready || busy) seen++;
        end
        chk_val("t5 no_activity", 32'(seen), 32'd0);
        run_op(8'h10, "t5_after", e);
        chk_val("t5 value", 32'(result), 32'h00000100);
        idle_check("t5", e);

        // Back-to-back: second start issued in the ready cycle.
        run_op(8'h07, "t6_first", e);
        chk_val("t6 first", 32'(result), 32'h00000031);
        run_op(8'h0B, "t6_second", e);
        chk_val("t6 second", 32'(result), 32'h00000079);
        idle_check("t6", e);

        // Random operands, mixing back-to-back and idle gaps.
        for (int i = 0; i < 1000; i++) begin
            op = DW'($urandom);
            if ($urandom_range(3) == 0) op = op >> $urandom_range(DW - 1);
            run_op(op, "rand", e);
            if ($urandom_range(1) == 1) idle_check("rand", e);
        end

        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
